// File: rtl/z80_resp_pkg.sv
// Shared types for the Z80 bus responder: FSM state encoding and cycle kinds.
// The INTACK state exists only when Z80_RESP_INTACK_EN is defined.
package z80_resp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    HOLD    = 3'd2,
    RELEASE = 3'd3
`ifdef Z80_RESP_INTACK_EN
    ,
    INTACK  = 3'd4
`endif
  } respState_t;

  typedef enum logic [1:0] {
    MEM_RD = 2'd0,
    MEM_WR = 2'd1,
    IO_RD  = 2'd2,
    IO_WR  = 2'd3
  } cycleKind_t;

  function automatic logic kindIsIo(input logic [1:0] kind);
    return (kind == IO_RD) || (kind == IO_WR);
  endfunction

endpackage

// File: rtl/z80_bus_responder_decode.sv
// Combinational Z80 cycle-start decode: strobes in, cycle kind / valid out.
// Refresh cycles (MREQ with neither RD nor WR) never produce a valid start.
module z80_cycle_decode
  import z80_resp_pkg::*;
(
  input  logic       nM1,
  input  logic       nMREQ,
  input  logic       nIORQ,
  input  logic       nRD,
  input  logic       nWR,
  output logic       cycleValid,
  output logic [1:0] cycleKind,
  output logic       intAck
);

  logic strobe;
  logic memStart;
  logic ioStart;

  assign strobe   = !nRD || !nWR;
  assign memStart = !nMREQ && strobe;
  assign ioStart  = !nIORQ && nM1 && strobe;
  assign intAck   = !nIORQ && !nM1;

  assign cycleValid = memStart || ioStart;

  always_comb begin
    cycleKind = MEM_RD;
    if (memStart) cycleKind = nWR ? MEM_RD : MEM_WR;
    else          cycleKind = nWR ? IO_RD : IO_WR;
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus responder: turns CPU memory/I/O cycles into backend requests, holding
// the CPU with nWAIT until the backend answers. Optional INTACK via Z80_RESP_INTACK_EN.
module z80_bus_responder
  import z80_resp_pkg::*;
#(
  parameter int         MIN_WAIT   = 0,
  parameter logic [7:0] INT_VECTOR = 8'hFF
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  input  logic        nM1,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  output logic [7:0]  D_out,
  output logic        D_oe,
  output logic        nWAIT,
  output logic        nINT,
  output logic        be_req,
  output logic        be_io,
  output logic        be_we,
  output logic [15:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic        be_ack,
  input  logic [7:0]  be_rdata,
  input  logic        int_req,
  output logic [2:0]  dbgState
);

  // Backend handshake: be_req is a one-cycle pulse with be_addr/be_io/be_we/be_wdata
  // stable from then on; be_ack (with be_rdata) may come in that same cycle or later
  // and is only listened to in ACCESS, where it is remembered until the wait elapses.
  localparam logic [3:0] MinWaitW = 4'(MIN_WAIT);

  respState_t state, stateNext;
  logic       cycleValid;
  logic [1:0] cycleKind;
  logic       intAck;
  logic [2:0] waitCnt;
  logic       ackSeen;
  logic       accessDone;

  z80_cycle_decode u_decode (
    .nM1       (nM1),
    .nMREQ     (nMREQ),
    .nIORQ     (nIORQ),
    .nRD       (nRD),
    .nWR       (nWR),
    .cycleValid(cycleValid),
    .cycleKind (cycleKind),
    .intAck    (intAck)
  );

  // waitCnt holds completed ACCESS cycles, so the current one is waitCnt+1.
  assign accessDone = (ackSeen || be_ack) && (({1'b0, waitCnt} + 4'd1) >= MinWaitW);
  assign dbgState   = state;

  always_comb begin
    stateNext = state;
    nWAIT     = 1'b1;
    D_oe      = 1'b0;
    case (state)
      IDLE: begin
        if (cycleValid) begin
          stateNext = ACCESS;
          nWAIT     = !nRESET;
        end
`ifdef Z80_RESP_INTACK_EN
        else if (intAck) stateNext = INTACK;
`endif
      end
      ACCESS: begin
        nWAIT = 1'b0;
        if (accessDone) stateNext = (nRD && nWR) ? RELEASE : HOLD;
      end
      HOLD: begin
        D_oe = !be_we && !nRD;
        if (nRD && nWR) stateNext = RELEASE;
      end
      RELEASE: begin
        if (nMREQ && nIORQ) stateNext = IDLE;
      end
`ifdef Z80_RESP_INTACK_EN
      INTACK: begin
        D_oe = !nIORQ;
        if (nIORQ) stateNext = RELEASE;
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= IDLE;
      D_out    <= 8'h00;
      be_req   <= 1'b0;
      be_io    <= 1'b0;
      be_we    <= 1'b0;
      be_addr  <= 16'h0000;
      be_wdata <= 8'h00;
      waitCnt  <= 3'd0;
      ackSeen  <= 1'b0;
    end else begin
      state  <= stateNext;
      be_req <= 1'b0;
      case (state)
        IDLE: begin
          if (cycleValid) begin
            be_addr  <= A;
            be_io    <= kindIsIo(cycleKind);
            be_we    <= ~nWR;
            be_wdata <= D_in;
            be_req   <= 1'b1;
            waitCnt  <= 3'd0;
            ackSeen  <= 1'b0;
          end
`ifdef Z80_RESP_INTACK_EN
          else if (intAck) D_out <= INT_VECTOR;
`endif
        end
        ACCESS: begin
          if (be_ack) ackSeen <= 1'b1;
          if (waitCnt != 3'd7) waitCnt <= waitCnt + 3'd1;
          if (be_ack && !ackSeen && !be_we) D_out <= be_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef Z80_RESP_INTACK_EN
  // A fresh request in the acknowledge cycle keeps nINT low.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)                                        nINT <= 1'b1;
    else if (int_req)                                   nINT <= 1'b0;
    else if (state == IDLE && !cycleValid && intAck)    nINT <= 1'b1;
  end
`else
  logic unusedIntSignals;
  assign unusedIntSignals = int_req ^ intAck;
  assign nINT = 1'b1;
`endif

endmodule
